sprite_row_fetcher: RTL and testbench
=====================================

Name: sprite_row_fetcher

Overview:
- Reader side of the sprite/tile OCM ROMs (ground brick, spine, spine_move, save_point, save_point2, arrow_right).
- Accepts a request for one row of one sprite and generates the ROM read addresses plus the ROM select.
- Absorbs the ROM's 1-cycle registered read latency.
- Streams colour indices to the pixel compositor over a valid/ready handshake with full backpressure.

Parameters:
- ADDR_W, 13, ROM read_address width.
- IDX_W, 4, colour index width.
- TILE_H, 20, rows per sprite (all sprites).
- NARROW_W, 20, width of sprite ids 0-4.
- WIDE_W, 40, width of sprite id 5 (arrow_right).

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high.
- start  in  1  request strobe; sampled only in IDLE.
- tile_id  in  3  0 brick_ground, 1 spine, 2 spine_move, 3 save_point, 4 save_point2, 5 arrow_right.
- row  in  5  sprite row, 0..TILE_H-1.
- mirror  in  1  horizontal flip request.
- busy  out  1  high from the accepted start until done.
- rom_sel  out  3  selects which ROM's color_idx is muxed onto rom_data; equals the latched tile_id.
- rom_addr  out  ADDR_W  read_address driven to all ROMs.
- rom_data  in  IDX_W  muxed color_idx; valid 1 cycle after rom_addr.
- pix_valid  out  1  output pixel valid.
- pix_ready  in  1  consumer ready.
- pix_idx  out  IDX_W  colour index.
- pix_col  out  6  screen-order column, 0..W-1.
- pix_last  out  1  high with the final pixel of the row.
- done  out  1  1-cycle pulse when the row is finished or rejected.
- err  out  1  1-cycle pulse with done on a rejected request.

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high.
- Reset values: busy=0, pix_valid=0, pix_last=0, done=0, err=0, rom_addr=0, rom_sel=0, pix_idx=0, pix_col=0. Reset forces IDLE, discards the in-flight read, and empties the skid buffer, including when asserted mid-row.
- Width: W = WIDE_W when tile_id==5, else NARROW_W.
- Address: rom_addr = row*W + c, computed at full ADDR_W without truncation. Maximum value is 799.
- Column order: c counts 0..W-1. When mirror is in effect, the source column is W-1-c while pix_col still reports c.
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE:
  - start with tile_id>5 or row>=TILE_H: pulse done and err the next cycle, emit no pixels, stay IDLE.
  - Valid start: latch tile_id/row/mirror, set busy, go to ISSUE.
- ISSUE: one address per cycle, under the credit rule. When the last column has been issued, go to DRAIN.
- DRAIN: wait until every pixel has been handed off, pulse done, clear busy, return to IDLE.
  - Done rises the cycle after the pix_last handshake.
  - Next start is accepted the cycle after done.
- Credit rule: a 2-entry output skid buffer. An address issues only if (buffer occupancy + reads in flight) < 2, so no returned ROM data is ever dropped.
- Handoff: pix_idx/pix_col/pix_last hold stable while pix_valid && !pix_ready.
- Throughput: with pix_ready held high, exactly one pixel per cycle after a 2-cycle initial latency (start -> first pix_valid).
- start while busy is ignored. Inputs are not re-sampled mid-row.

Optional Feature:
- Macro: SPRITE_MIRROR_EN.
- Defined: the mirror input selects the reversed source column as above.
- Undefined: the mirror port exists but is ignored; columns are always read in ascending order.

Decomposition:
- Shared package sprite_pkg holds:
  - the tile_id enum (BRICK_GROUND..ARROW_RIGHT);
  - TILE_H, NARROW_W, WIDE_W, ADDR_W, IDX_W;
  - a width-lookup function.
- One sub-module: sprite_skid2, the 2-entry valid/ready skid buffer carrying {idx, col, last}.

Test Plan:
- ROM model returns mem[a]=a%16. start tile 0, row 0, pix_ready=1 -> rom_addr 0..19; pix_idx 0,1,..15,0..3; pix_last with col 19; done 1 cycle later.
- tile 5, row 19 -> addresses 760..799; 40 pixels; pix_col 0..39.
- SPRITE_MIRROR_EN defined: tile 0, row 1, mirror=1 -> addresses 39 down to 20, pix_col 0..19. Undefined: addresses 20..39.
- pix_ready toggling pseudo-randomly, tile 3 row 7 -> all 20 pixels in order; no loss or duplicate; outputs stable while stalled; issue never exceeds 2 outstanding.
- start row=20, or tile_id=6 -> done+err pulse, zero pix_valid, busy stays 0.
- Reset after 5 pixels of tile 5 -> next cycle pix_valid=0, busy=0. A fresh start then runs a clean full row from address row*40.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared types, geometry constants and address helpers for the sprite row fetcher.
// The optional SPRITE_MIRROR_EN build macro is consumed by sprite_row_fetcher.
package sprite_pkg;

  localparam int ADDR_W   = 13;
  localparam int IDX_W    = 4;
  localparam int COL_W    = 6;
  localparam int TILE_H   = 20;
  localparam int NARROW_W = 20;
  localparam int WIDE_W   = 40;

  typedef enum logic [2:0] {
    BRICK_GROUND = 3'd0,
    SPINE        = 3'd1,
    SPINE_MOVE   = 3'd2,
    SAVE_POINT   = 3'd3,
    SAVE_POINT2  = 3'd4,
    ARROW_RIGHT  = 3'd5
  } tile_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [COL_W-1:0] col;
    logic             last;
  } pix_t;

  function automatic logic [COL_W-1:0] tile_width(input logic [2:0] t);
    return (t == 3'(ARROW_RIGHT)) ? COL_W'(WIDE_W) : COL_W'(NARROW_W);
  endfunction

  // Source address of screen column c; mirrored rows read from the right edge.
  function automatic logic [ADDR_W-1:0] calc_addr(input logic [2:0] t, input logic [4:0] r,
                                                  input logic m, input logic [COL_W-1:0] c);
    logic [COL_W-1:0] w;
    logic [COL_W-1:0] src;
    w   = tile_width(t);
    src = m ? (w - COL_W'(1) - c) : c;
    return ADDR_W'(r) * ADDR_W'(w) + ADDR_W'(src);
  endfunction

endpackage

// File: rtl/sprite_skid2.sv
// Two-entry output buffer; entry e0_q is the registered head presented to the consumer.
module sprite_skid2
  import sprite_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       in_valid_i,
  input  pix_t       in_pix_i,
  input  logic       out_ready_i,
  output logic       out_valid_o,
  output pix_t       out_pix_o,
  output logic [1:0] occ_o
);

  logic [1:0] cnt_q;
  pix_t       e0_q;
  pix_t       e1_q;
  logic       pop;

  // Handshake: a pixel transfers on a clock edge where out_valid_o && out_ready_i;
  // the head is held unchanged otherwise. The producer never pushes into a full,
  // non-popping buffer (guaranteed by the fetcher's credit check).
  assign pop         = (cnt_q != 2'd0) && out_ready_i;
  assign out_valid_o = (cnt_q != 2'd0);
  assign out_pix_o   = e0_q;
  assign occ_o       = cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= 2'd0;
      e0_q  <= '0;
      e1_q  <= '0;
    end else begin
      case ({pop, in_valid_i})
        2'b01: begin
          if (cnt_q == 2'd0) e0_q <= in_pix_i;
          else               e1_q <= in_pix_i;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b10: begin
          if (cnt_q == 2'd2) e0_q <= e1_q;
          cnt_q <= cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            e0_q <= in_pix_i;
          end else begin
            e0_q <= e1_q;
            e1_q <= in_pix_i;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sprite_row_fetcher.sv
// Fetches one sprite row from the OCM ROMs and streams colour indices with backpressure.
// Build macro SPRITE_MIRROR_EN enables the horizontal flip input.
module sprite_row_fetcher
  import sprite_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic [2:0]        tile_id,
  input  logic [4:0]        row,
  input  logic              mirror,
  output logic              busy,
  output logic [2:0]        rom_sel,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [IDX_W-1:0]  rom_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [IDX_W-1:0]  pix_idx,
  output logic [COL_W-1:0]  pix_col,
  output logic              pix_last,
  output logic              done,
  output logic              err,
  output state_t            dbg_state_o
);

  state_t            st_q;
  logic [2:0]        tile_q;
  logic [4:0]        row_q;
  logic              mirror_q;
  logic [COL_W-1:0]  col_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rd_q;
  logic [COL_W-1:0]  rd_col_q;
  logic              rd_last_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  logic       mirror_in;
  logic [1:0] occ;
  logic       pop;
  logic       credit_ok;
  logic       issue;
  logic       last_col;
  logic       req_bad;
  pix_t       rd_pix;
  pix_t       out_pix;

`ifdef SPRITE_MIRROR_EN
  assign mirror_in = mirror;
`else
  // Flip disabled: the port is kept but forced to ascending column order.
  assign mirror_in = mirror & 1'b0;
`endif

  // A slot freed by this cycle's handoff can be reused at once, keeping one pixel per cycle.
  assign pop       = pix_valid && pix_ready;
  assign credit_ok = ({1'b0, occ} + {2'b0, rd_q}) < (3'd2 + {2'b0, pop});
  assign issue     = (st_q == ST_ISSUE) && credit_ok;
  assign last_col  = (col_q == tile_width(tile_q) - COL_W'(1));
  assign req_bad   = (tile_id > 3'(ARROW_RIGHT)) || (row >= 5'(TILE_H));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      st_q      <= ST_IDLE;
      tile_q    <= 3'd0;
      row_q     <= 5'd0;
      mirror_q  <= 1'b0;
      col_q     <= '0;
      addr_q    <= '0;
      rd_q      <= 1'b0;
      rd_col_q  <= '0;
      rd_last_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      rd_q   <= issue;
      if (issue) begin
        rd_col_q  <= col_q;
        rd_last_q <= last_col;
      end
      case (st_q)
        ST_IDLE: begin
          if (start) begin
            if (req_bad) begin
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end else begin
              tile_q   <= tile_id;
              row_q    <= row;
              mirror_q <= mirror_in;
              col_q    <= '0;
              addr_q   <= calc_addr(tile_id, row, mirror_in, '0);
              busy_q   <= 1'b1;
              st_q     <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (issue) begin
            if (last_col) begin
              st_q <= ST_DRAIN;
            end else begin
              col_q  <= col_q + COL_W'(1);
              addr_q <= calc_addr(tile_q, row_q, mirror_q, col_q + COL_W'(1));
            end
          end
        end
        ST_DRAIN: begin
          if (pop && out_pix.last) begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
            st_q   <= ST_IDLE;
          end
        end
        default: st_q <= ST_IDLE;
      endcase
    end
  end

  assign rd_pix = '{idx: rom_data, col: rd_col_q, last: rd_last_q};

  sprite_skid2 u_skid (
    .clk_i       (Clk),
    .rst_i       (Reset),
    .in_valid_i  (rd_q),
    .in_pix_i    (rd_pix),
    .out_ready_i (pix_ready),
    .out_valid_o (pix_valid),
    .out_pix_o   (out_pix),
    .occ_o       (occ)
  );

  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign rom_sel     = tile_q;
  assign rom_addr    = addr_q;
  assign pix_idx     = out_pix.idx;
  assign pix_col     = out_pix.col;
  assign pix_last    = out_pix.last;
  assign dbg_state_o = st_q;

endmodule

// File: tb/tb_sprite_row_fetcher.sv
// Directed bench for sprite_row_fetcher with a registered ROM model (mem[a] = a % 16).
module tb_sprite_row_fetcher;
  import sprite_pkg::*;

  logic              Clk = 1'b0;
  logic              Reset = 1'b1;
  logic              start = 1'b0;
  logic [2:0]        tile_id = '0;
  logic [4:0]        row = '0;
  logic              mirror = 1'b0;
  logic              busy;
  logic [2:0]        rom_sel;
  logic [ADDR_W-1:0] rom_addr;
  logic [IDX_W-1:0]  rom_data = '0;
  logic              pix_valid;
  logic              pix_ready = 1'b1;
  logic [IDX_W-1:0]  pix_idx;
  logic [COL_W-1:0]  pix_col;
  logic              pix_last;
  logic              done;
  logic              err;
  state_t            dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [10:0] exp_q[$];

  sprite_row_fetcher dut (
    .Clk(Clk), .Reset(Reset), .start(start), .tile_id(tile_id), .row(row),
    .mirror(mirror), .busy(busy), .rom_sel(rom_sel), .rom_addr(rom_addr),
    .rom_data(rom_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_idx(pix_idx), .pix_col(pix_col), .pix_last(pix_last), .done(done),
    .err(err), .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 Clk = ~Clk;

  // registered ROM: data for an address appears one edge later
  always @(posedge Clk) rom_data <= rom_addr[3:0];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic pulse_start(input logic [2:0] t, input logic [4:0] r, input logic m);
    @(posedge Clk); #1;
    start = 1'b1; tile_id = t; row = r; mirror = m;
    @(posedge Clk); #1;
    start = 1'b0; tile_id = 3'd6; row = 5'd31; mirror = ~m;
  endtask

  task automatic run_row(input logic [2:0] t, input logic [4:0] r, input logic m, input bit rnd);
    int w, cyc, first_cyc, last_cyc, a, src;
    bit m_eff, got_last, stalled;
    logic [10:0] cur, held, e;
`ifdef SPRITE_MIRROR_EN
    m_eff = m;
`else
    m_eff = 1'b0;
`endif
    w = (t == 3'd5) ? 40 : 20;
    exp_q.delete();
    for (int c = 0; c < w; c++) begin
      src = m_eff ? (w - 1 - c) : c;
      a = int'(r) * w + src;
      exp_q.push_back({4'(a % 16), 6'(c), (c == w - 1)});
    end
    pix_ready = 1'b1;
    pulse_start(t, r, m);
    if (rnd) pix_ready = 1'($urandom_range(0, 1));
    @(negedge Clk);
    check("busy_on", busy, 1);
    check("rom_sel", rom_sel, t);
    check("addr_first", rom_addr, int'(r) * w + (m_eff ? w - 1 : 0));
    cyc = 0; first_cyc = -1; last_cyc = -1; got_last = 0; stalled = 0; held = '0;
    while (!got_last && cyc < 600) begin
      cur = {pix_idx, pix_col, pix_last};
      if (stalled) check("stall_hold", {pix_valid, cur}, {1'b1, held});
      if (pix_valid && first_cyc < 0) first_cyc = cyc;
      if (pix_valid && pix_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_pix", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("pix", cur, e);
        end
        got_last = pix_last;
        last_cyc = cyc;
      end
      stalled = pix_valid && !pix_ready;
      held = cur;
      @(posedge Clk); #1;
      if (rnd) pix_ready = 1'($urandom_range(0, 1));
      @(negedge Clk);
      cyc++;
    end
    check("row_end", got_last, 1);
    check("exp_left", exp_q.size(), 0);
    check("done_pulse", {done, err, busy}, 3'b100);
    if (!rnd) begin
      check("first_lat", first_cyc, 2);
      check("thruput", last_cyc - first_cyc, w - 1);
    end
    @(negedge Clk);
    check("done_clr", {done, err, busy, pix_valid}, 4'b0000);
  endtask

  task automatic reject(input logic [2:0] t, input logic [4:0] r);
    pulse_start(t, r, 1'b0);
    @(negedge Clk);
    check("rej_pulse", {done, err, busy, pix_valid}, 4'b1100);
    @(negedge Clk);
    check("rej_after", {done, err, busy, pix_valid}, 4'b0000);
  endtask

  task automatic reset_mid_row();
    int seen, guard;
    pix_ready = 1'b1;
    pulse_start(3'd5, 5'd2, 1'b0);
    seen = 0; guard = 0;
    while (seen < 5 && guard < 50) begin
      @(negedge Clk);
      if (pix_valid && pix_ready) seen++;
      guard++;
    end
    check("pre_reset_pix", seen, 5);
    @(posedge Clk); #1;
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    @(negedge Clk);
    check("rst_mid", {pix_valid, busy, done, err}, 4'b0000);
    check("rst_mid_addr", rom_addr, 0);
    repeat (3) @(negedge Clk);
    check("rst_quiet", {pix_valid, busy}, 2'b00);
  endtask

  initial begin
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    @(negedge Clk);
    check("rst_ctrl", {busy, pix_valid, pix_last, done, err}, 5'b00000);
    check("rst_addr", rom_addr, 0);
    check("rst_sel", rom_sel, 0);
    check("rst_pix", {pix_idx, pix_col}, 0);

    run_row(3'd0, 5'd0, 1'b0, 1'b0);
    run_row(3'd5, 5'd19, 1'b0, 1'b0);
    run_row(3'd0, 5'd1, 1'b1, 1'b0);
    run_row(3'd3, 5'd7, 1'b0, 1'b1);
    run_row(3'd5, 5'd4, 1'b1, 1'b1);
    reject(3'd0, 5'd20);
    reject(3'd6, 5'd0);
    reject(3'd7, 5'd31);
    reset_mid_row();
    run_row(3'd5, 5'd2, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
